// File: rtl/gcm_key_loader.sv
// gcm_key_loader: assembles 128/256-bit AES keys from a 128-bit beat stream,
// queues them, hands each one to aes_top for expansion, and holds it for gcm
// until gcm_done retires it.
//
// Beat handshake: a beat transfers on a rising edge where key_in_valid and
// key_in_ready are both 1. key_in_ready depends only on fifo_level and never on
// key_in_valid. The source may present data before ready and must hold it
// stable until the transfer edge. key_in_ready is registered, so a pop in the
// same cycle cannot raise it early.
module gcm_key_loader #(
  parameter int BLK_BITS         = 128,
  parameter int AES_MAX_KEY_BITS = 256,
  parameter int KEY_FIFO_DEPTH   = 4,
  parameter int EXPAND_TIMEOUT   = 64,
  localparam int LVL_W           = $clog2(KEY_FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BLK_BITS-1:0]         key_in_blk,
  input  logic                        key_in_mode,
  input  logic                        key_in_valid,
  output logic                        key_in_ready,
  output logic [AES_MAX_KEY_BITS-1:0] aes_key,
  output logic                        aes_en_key,
  output logic                        aes128_mode,
  output logic                        aes256_mode,
  input  logic                        aes_op_in_progress,
  input  logic                        aes_done,
  input  logic                        gcm_done,
  output logic                        key_expanded,
  output logic                        key_err,
  output logic [LVL_W-1:0]            fifo_level,
  output logic [1:0]                  state_dbg
);

  localparam int PTR_W = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;
  localparam int CNT_W = (EXPAND_TIMEOUT > 1) ? $clog2(EXPAND_TIMEOUT) : 1;
  // FIFO entry: {mode, key}; mode=1 means AES-256
  localparam int ENT_W = AES_MAX_KEY_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_EXP = 2'd2,
    S_READY    = 2'd3
  } state_t;

  state_t state;

  logic [ENT_W-1:0]    fifo_mem [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    level_next;
  logic                have_beat0;
  logic [BLK_BITS-1:0] beat0;
  logic                beat_fire;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    push_entry;
  logic [ENT_W-1:0]    head;
  logic [CNT_W-1:0]    exp_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(KEY_FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign fifo_level = level;
  assign state_dbg  = state;
  assign head       = fifo_mem[rd_ptr];

  // Assembler decode: which beat completes a key and what gets committed
  always_comb begin
    beat_fire  = key_in_valid && key_in_ready;
    push       = 1'b0;
    push_entry = '0;
    if (beat_fire) begin
      if (have_beat0) begin
        // second beat of a 256-bit key; key_in_mode is ignored here
        push       = 1'b1;
        push_entry = {1'b1, beat0, key_in_blk};
      end else if (!key_in_mode) begin
        push       = 1'b1;
        push_entry = {1'b0, key_in_blk, {BLK_BITS{1'b0}}};
      end
    end
  end

  // Pop only when the issuer is idle and aes_top is free
  always_comb begin
    pop        = (state == S_IDLE) && (level != '0) && !aes_op_in_progress;
    level_next = level;
    if (push && !pop)      level_next = level + LVL_W'(1);
    else if (!push && pop) level_next = level - LVL_W'(1);
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, level, registered ready and the held first beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      key_in_ready <= 1'b0;
      have_beat0   <= 1'b0;
      beat0        <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      level        <= level_next;
      key_in_ready <= (level_next < LVL_W'(KEY_FIFO_DEPTH));
      if (beat_fire) begin
        if (have_beat0) begin
          have_beat0 <= 1'b0;
        end else if (key_in_mode) begin
          have_beat0 <= 1'b1;
          beat0      <= key_in_blk;
        end
      end
    end
  end

  // Issue FSM: IDLE -> ISSUE (strobe) -> WAIT_EXP -> READY -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      aes_key      <= '0;
      aes_en_key   <= 1'b0;
      aes128_mode  <= 1'b0;
      aes256_mode  <= 1'b0;
      key_expanded <= 1'b0;
      key_err      <= 1'b0;
      exp_cnt      <= '0;
    end else begin
      aes_en_key <= 1'b0;
      key_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            aes_key     <= head[AES_MAX_KEY_BITS-1:0];
            aes128_mode <= !head[AES_MAX_KEY_BITS];
            aes256_mode <= head[AES_MAX_KEY_BITS];
            aes_en_key  <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          exp_cnt <= '0;
          state   <= S_WAIT_EXP;
        end
        S_WAIT_EXP: begin
          // aes_done takes priority over a coincident timeout
          if (aes_done) begin
            key_expanded <= 1'b1;
            state        <= S_READY;
          end else if (exp_cnt == CNT_W'(EXPAND_TIMEOUT - 1)) begin
            key_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            exp_cnt <= exp_cnt + CNT_W'(1);
          end
        end
        S_READY: begin
          // aes_done here comes from cipher ops and is ignored
          if (gcm_done) begin
            key_expanded <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_key_loader.sv
// Bench for gcm_key_loader: drives key beats, models aes_top/gcm handshakes,
// and checks issued keys against an expected queue in push order.
module tb_gcm_key_loader;

  localparam int BLK   = 128;
  localparam int KEYW  = 256;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int LVLW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [BLK-1:0]  key_in_blk = '0;
  logic            key_in_mode = 1'b0;
  logic            key_in_valid = 1'b0;
  logic            key_in_ready;
  logic [KEYW-1:0] aes_key;
  logic            aes_en_key;
  logic            aes128_mode;
  logic            aes256_mode;
  logic            aes_op_in_progress = 1'b0;
  logic            aes_done = 1'b0;
  logic            gcm_done = 1'b0;
  logic            key_expanded;
  logic            key_err;
  logic [LVLW-1:0] fifo_level;
  logic [1:0]      state_dbg;

  int total = 0;
  int bad = 0;
  int issue_cnt = 0;
  logic [KEYW:0] exp_q[$];
  logic [KEYW:0] exp_e;

  gcm_key_loader #(
    .BLK_BITS(BLK), .AES_MAX_KEY_BITS(KEYW),
    .KEY_FIFO_DEPTH(DEPTH), .EXPAND_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .key_in_blk(key_in_blk), .key_in_mode(key_in_mode),
    .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .aes_key(aes_key), .aes_en_key(aes_en_key),
    .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
    .aes_op_in_progress(aes_op_in_progress), .aes_done(aes_done),
    .gcm_done(gcm_done), .key_expanded(key_expanded), .key_err(key_err),
    .fifo_level(fifo_level), .state_dbg(state_dbg)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard: every expand strobe must carry the oldest expected key
  always @(negedge clk) begin
    if (!reset && aes_en_key) begin
      issue_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got key=%h mode256=%b, required no issue", aes_key, aes256_mode);
      end else begin
        exp_e = exp_q.pop_front();
        if ({aes256_mode, aes_key} !== exp_e || aes128_mode !== ~exp_e[KEYW]) begin
          bad++;
          $display("FAIL issue_key: got m128=%b m256=%b key=%h, required m256=%b key=%h",
                   aes128_mode, aes256_mode, aes_key, exp_e[KEYW], exp_e[KEYW-1:0]);
        end
      end
    end
  end

  // driver: present one beat and hold it until it transfers
  task automatic send_beat(input logic [BLK-1:0] blk, input logic mode, input string name);
    int n = 0;
    logic acc;
    key_in_blk   = blk;
    key_in_mode  = mode;
    key_in_valid = 1'b1;
    acc = key_in_ready;
    while (!acc && n < 200) begin
      @(posedge clk); #1;
      acc = key_in_ready;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL %s: key_in_ready stayed 0 for 200 cycles, required 1", name);
    end
    @(posedge clk); #1;
    key_in_valid = 1'b0;
  endtask

  task automatic send_key128(input logic [BLK-1:0] k, input string name);
    send_beat(k, 1'b0, name);
    exp_q.push_back({1'b0, k, {BLK{1'b0}}});
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (aes_en_key !== 1'b1 && n < 200);
    total++;
    if (aes_en_key !== 1'b1) begin
      bad++;
      $display("FAIL %s: aes_en_key=%b after 200 cycles, required 1", name, aes_en_key);
    end
  endtask

  // aes_top model: answer the strobe with a one-cycle aes_done in WAIT_EXP
  task automatic expand_ok(input string name);
    @(posedge clk); #1;
    aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
    @(negedge clk);
    total++;
    if (key_expanded !== 1'b1 || state_dbg !== 2'd3) begin
      bad++;
      $display("FAIL %s_expanded: key_expanded=%b state=%0d, required 1 and 3", name, key_expanded, state_dbg);
    end
  endtask

  // gcm model: retire the current key
  task automatic retire(input string name);
    gcm_done = 1'b1;
    @(posedge clk); #1;
    gcm_done = 1'b0;
    @(negedge clk);
    total++;
    if (key_expanded !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL %s_retire: key_expanded=%b state=%0d, required 0 and 0", name, key_expanded, state_dbg);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (aes_key !== '0 || aes_en_key !== 1'b0 || aes128_mode !== 1'b0 || aes256_mode !== 1'b0 ||
        key_expanded !== 1'b0 || key_err !== 1'b0 || fifo_level !== '0 || key_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: key=%h en=%b m128=%b m256=%b kx=%b err=%b lvl=%0d rdy=%b, required all 0",
               aes_key, aes_en_key, aes128_mode, aes256_mode, key_expanded, key_err, fifo_level, key_in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (key_in_ready !== 1'b1 || fifo_level !== '0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b lvl=%0d state=%0d, required 1 0 0", key_in_ready, fifo_level, state_dbg);
    end
  endtask

  task automatic test_key128();
    logic [BLK-1:0] k;
    int c0;
    k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    c0 = issue_cnt;
    send_key128(k, "k128_send");
    @(negedge clk);
    total++;
    if (aes_en_key !== 1'b0) begin
      bad++;
      $display("FAIL k128_latency_early: aes_en_key=%b one cycle after handshake, required 0", aes_en_key);
    end
    @(negedge clk);
    total++;
    if (aes_en_key !== 1'b1) begin
      bad++;
      $display("FAIL k128_latency: aes_en_key=%b two cycles after handshake, required 1", aes_en_key);
    end
    expand_ok("k128");
    retire("k128");
    repeat (3) @(negedge clk);
    total++;
    if (issue_cnt !== c0 + 1) begin
      bad++;
      $display("FAIL k128_single_strobe: strobes=%0d, required 1", issue_cnt - c0);
    end
  endtask

  task automatic test_key256();
    logic [BLK-1:0] b0;
    logic [BLK-1:0] b1;
    logic quiet;
    b0 = 128'h603deb1015ca71be2b73aef0857d7781;
    b1 = 128'h1f352c073b6108d72d9810a30914dff4;
    send_beat(b0, 1'b1, "k256_beat0");
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (aes_en_key !== 1'b0 || fifo_level !== '0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL k256_hold: issue or commit seen with only beat0, required none");
    end
    // mode on beat1 deliberately 0: it must be ignored
    send_beat(b1, 1'b0, "k256_beat1");
    exp_q.push_back({1'b1, b0, b1});
    wait_en("k256_issue");
    expand_ok("k256");
    retire("k256");
  endtask

  task automatic test_backpressure();
    logic [BLK-1:0] k;
    send_key128({$urandom, $urandom, $urandom, $urandom}, "bp_first");
    wait_en("bp_first_issue");
    expand_ok("bp_first");
    for (int i = 0; i < DEPTH; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      send_key128(k, "bp_fill");
    end
    @(negedge clk);
    total++;
    if (fifo_level !== LVLW'(DEPTH) || key_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: lvl=%0d rdy=%b, required %0d and 0", fifo_level, key_in_ready, DEPTH);
    end
    // an offered beat must not be taken while full
    key_in_blk   = 128'hdeadbeef;
    key_in_mode  = 1'b0;
    key_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_in_valid = 1'b0;
    total++;
    if (fifo_level !== LVLW'(DEPTH)) begin
      bad++;
      $display("FAIL bp_no_accept: lvl=%0d, required %0d", fifo_level, DEPTH);
    end
    retire("bp_first");
    for (int i = 0; i < DEPTH; i++) begin
      wait_en("bp_drain_issue");
      expand_ok("bp_drain");
      retire("bp_drain");
    end
    total++;
    if (fifo_level !== '0 || key_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_empty: lvl=%0d rdy=%b, required 0 and 1", fifo_level, key_in_ready);
    end
  endtask

  task automatic test_spurious_done();
    logic [KEYW-1:0] held;
    int c0;
    send_key128({$urandom, $urandom, $urandom, $urandom}, "sp_first");
    wait_en("sp_issue");
    expand_ok("sp");
    send_key128({$urandom, $urandom, $urandom, $urandom}, "sp_next");
    @(negedge clk);
    held = aes_key;
    c0   = issue_cnt;
    repeat (3) begin
      aes_done = 1'b1;
      @(posedge clk); #1;
      aes_done = 1'b0;
      @(negedge clk);
    end
    total++;
    if (key_expanded !== 1'b1 || state_dbg !== 2'd3 || aes_key !== held || issue_cnt !== c0 || fifo_level !== LVLW'(1)) begin
      bad++;
      $display("FAIL sp_stable: kx=%b state=%0d key=%h strobes=%0d lvl=%0d, required 1 3 %h 0 1",
               key_expanded, state_dbg, aes_key, issue_cnt - c0, fifo_level, held);
    end
    retire("sp");
    wait_en("sp_next_issue");
    expand_ok("sp_next");
    retire("sp_next");
  endtask

  task automatic test_timeout();
    logic clean;
    send_key128({$urandom, $urandom, $urandom, $urandom}, "to_a");
    send_key128({$urandom, $urandom, $urandom, $urandom}, "to_b");
    wait_en("to_issue");
    clean = 1'b1;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (key_err !== 1'b0 || key_expanded !== 1'b0) clean = 1'b0;
    end
    total++;
    if (!clean) begin
      bad++;
      $display("FAIL to_early: key_err or key_expanded rose before %0d cycles, required 0", TMO);
    end
    @(negedge clk);
    total++;
    if (key_err !== 1'b1 || key_expanded !== 1'b0) begin
      bad++;
      $display("FAIL to_err: key_err=%b kx=%b at expiry, required 1 and 0", key_err, key_expanded);
    end
    wait_en("to_next_issue");
    total++;
    if (key_err !== 1'b0) begin
      bad++;
      $display("FAIL to_pulse: key_err=%b one cycle later, required 0", key_err);
    end
    expand_ok("to_next");
    retire("to_next");
  endtask

  task automatic test_done_at_expiry();
    send_key128({$urandom, $urandom, $urandom, $urandom}, "dx");
    wait_en("dx_issue");
    repeat (TMO) @(negedge clk);
    aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
    @(negedge clk);
    total++;
    if (key_expanded !== 1'b1 || key_err !== 1'b0) begin
      bad++;
      $display("FAIL dx_priority: kx=%b key_err=%b, required 1 and 0", key_expanded, key_err);
    end
    retire("dx");
  endtask

  task automatic test_reset_midop();
    send_key128({$urandom, $urandom, $urandom, $urandom}, "rm_a");
    wait_en("rm_issue");
    send_key128({$urandom, $urandom, $urandom, $urandom}, "rm_b");
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, "rm_beat0");
    @(negedge clk);
    total++;
    if (state_dbg !== 2'd2 || fifo_level !== LVLW'(1)) begin
      bad++;
      $display("FAIL rm_setup: state=%0d lvl=%0d, required 2 and 1", state_dbg, fifo_level);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (aes_key !== '0 || aes_en_key !== 1'b0 || aes128_mode !== 1'b0 || aes256_mode !== 1'b0 ||
        key_expanded !== 1'b0 || key_err !== 1'b0 || fifo_level !== '0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL rm_async: key=%h en=%b m128=%b m256=%b kx=%b err=%b lvl=%0d state=%0d, required all 0",
               aes_key, aes_en_key, aes128_mode, aes256_mode, key_expanded, key_err, fifo_level, state_dbg);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send_key128({$urandom, $urandom, $urandom, $urandom}, "rm_fresh");
    wait_en("rm_fresh_issue");
    expand_ok("rm_fresh");
    retire("rm_fresh");
  endtask

  initial begin
    test_reset();
    test_key128();
    test_key256();
    test_backpressure();
    test_spurious_done();
    test_timeout();
    test_done_at_expiry();
    test_reset_midop();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected keys never issued, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
